// File: rtl/game_pkg.sv
// Shared tic-tac-toe definitions: cell and winner codes, FSM states, board
// geometry, the winning-line table and small board access helpers.
package game_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_MOVE = 3'd1,
    ST_APPLY     = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Three rows, three columns, two diagonals.
  localparam logic [3:0] WIN_LINES [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] cells, input logic [3:0] idx);
    logic [1:0] code;
    case (idx)
      4'd0:    code = cells[1:0];
      4'd1:    code = cells[3:2];
      4'd2:    code = cells[5:4];
      4'd3:    code = cells[7:6];
      4'd4:    code = cells[9:8];
      4'd5:    code = cells[11:10];
      4'd6:    code = cells[13:12];
      4'd7:    code = cells[15:14];
      4'd8:    code = cells[17:16];
      default: code = CELL_EMPTY;
    endcase
    return code;
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] cells, input logic [3:0] idx,
                                           input logic [1:0] code);
    logic [17:0] r;
    r = cells;
    case (idx)
      4'd0:    r[1:0]   = code;
      4'd1:    r[3:2]   = code;
      4'd2:    r[5:4]   = code;
      4'd3:    r[7:6]   = code;
      4'd4:    r[9:8]   = code;
      4'd5:    r[11:10] = code;
      4'd6:    r[13:12] = code;
      4'd7:    r[15:14] = code;
      4'd8:    r[17:16] = code;
      default: r = cells;
    endcase
    return r;
  endfunction

  function automatic logic board_full(input logic [17:0] cells);
    logic full;
    full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cells[2*i +: 2] == CELL_EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/win_detector.sv
// Combinational three-in-a-row detector: win is high when any of the eight
// lines holds the given mark in all three cells.
module win_detector
  import game_pkg::*;
(
  input  logic [17:0] Cells,
  input  logic [1:0]  mark,
  output logic        win
);

  // Scan every winning line for three matching marks
  always_comb begin
    win = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((mark != CELL_EMPTY) &&
          (cell_at(Cells, WIN_LINES[l][0]) == mark) &&
          (cell_at(Cells, WIN_LINES[l][1]) == mark) &&
          (cell_at(Cells, WIN_LINES[l][2]) == mark)) begin
        win = 1'b1;
      end else begin
        win = win;
      end
    end
  end

endmodule

// File: rtl/move_applier.sv
// Tic-tac-toe move applier: accepts moves, updates the board, detects win/draw.
// Optional turn timer is built when MOVE_APPLIER_TURN_TIMER_EN is defined.
module move_applier
  import game_pkg::*;
#(
  parameter logic [31:0] TURN_CYCLES = 32'd500000000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move,
  output logic        move_ready,
  output logic        timeout,
  output logic [17:0] Cells,
  output logic        player,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        move_error
);

  state_e      state_q, state_d;
  logic [17:0] cells_q, cells_d;
  logic        player_q, player_d;
  logic [1:0]  winner_q, winner_d;
  logic [3:0]  move_q, move_d;
  logic        error_q, error_d;
  logic        ready_q, over_q;

  logic [1:0]  mark_s;
  logic        legal_s;
  logic        win_s;

  assign mark_s  = {player_q, ~player_q};
  assign legal_s = (move_q <= 4'd8) && (cell_at(cells_q, move_q) == CELL_EMPTY);

  win_detector u_win_detector (
    .Cells (cells_q),
    .mark  (mark_s),
    .win   (win_s)
  );

  // Next-state and board update; start overrides whatever the FSM is doing
  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    player_d = player_q;
    winner_d = winner_q;
    move_d   = move_q;
    error_d  = 1'b0;
    if (start) begin
      state_d  = ST_WAIT_MOVE;
      cells_d  = 18'd0;
      player_d = 1'b0;
      winner_d = WIN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT_MOVE: begin
          if (move_valid) begin
            move_d  = move;
            state_d = ST_APPLY;
          end else begin
            state_d = ST_WAIT_MOVE;
          end
        end
        ST_APPLY: begin
          if (legal_s) begin
            cells_d = set_cell(cells_q, move_q, mark_s);
            state_d = ST_CHECK;
          end else begin
            error_d = 1'b1;
            state_d = ST_WAIT_MOVE;
          end
        end
        ST_CHECK: begin
          if (win_s) begin
            winner_d = mark_s;
            state_d  = ST_DONE;
          end else if (board_full(cells_q)) begin
            winner_d = WIN_DRAW;
            state_d  = ST_DONE;
          end else begin
            player_d = ~player_q;
            state_d  = ST_WAIT_MOVE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Game state registers; handshake outputs are registered from the next state
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cells_q  <= 18'd0;
      player_q <= 1'b0;
      winner_q <= WIN_NONE;
      move_q   <= 4'd0;
      error_q  <= 1'b0;
      ready_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      player_q <= player_d;
      winner_q <= winner_d;
      move_q   <= move_d;
      error_q  <= error_d;
      ready_q  <= (state_d == ST_WAIT_MOVE);
      over_q   <= (state_d == ST_DONE);
    end
  end

`ifdef MOVE_APPLIER_TURN_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;

  // Turn timer: runs only while waiting with no offer, so an offer on the expiry cycle wins
  always_comb begin
    timer_d   = timer_q;
    timeout_d = 1'b0;
    if (start) begin
      timer_d = TURN_CYCLES;
    end else if ((state_q == ST_CHECK) && (state_d == ST_WAIT_MOVE)) begin
      timer_d = TURN_CYCLES;
    end else if ((state_q == ST_WAIT_MOVE) && !move_valid) begin
      if (timer_q <= 32'd1) begin
        timer_d   = TURN_CYCLES;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q - 32'd1;
      end
    end else begin
      timer_d = timer_q;
    end
  end

  // Timer and timeout pulse registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      timer_q   <= TURN_CYCLES;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // No timer in this build; the parameter is kept so both builds share one interface.
  assign timeout = (TURN_CYCLES == 32'd0) & 1'b0;
`endif

  assign move_ready = ready_q;
  assign game_over  = over_q;
  assign move_error = error_q;
  assign Cells      = cells_q;
  assign player     = player_q;
  assign winner     = winner_q;

endmodule
